// File: rtl/btb_pkg.sv
// Shared configuration, derived geometry and address-field helpers for the banked BTB.
package btb_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned BYTE_OFFSET = 3;
  localparam int unsigned FETCH_WIDTH = 4;
  localparam int unsigned DEPTH       = 1024;
  localparam int unsigned WAYS        = 2;
  localparam int unsigned BRANCH_TYPE = 2;

  localparam int unsigned FW_LOG   = $clog2(FETCH_WIDTH);
  localparam int unsigned BANK_W   = (FW_LOG > 0) ? FW_LOG : 1;
  localparam int unsigned SETS     = DEPTH / (FETCH_WIDTH * WAYS);
  localparam int unsigned SETS_LOG = $clog2(SETS);
  localparam int unsigned WAY_LOG  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_W    = PC_W - BYTE_OFFSET - FW_LOG - SETS_LOG;

  typedef enum logic {IDLE, CLEAR} flush_state_e;

  typedef struct packed {
    logic                   valid;
    logic [TAG_W-1:0]       tag;
    logic [PC_W-1:0]        target;
    logic [BRANCH_TYPE-1:0] ctype;
  } entry_t;

  function automatic logic [PC_W-1:0] lane_addr(input logic [PC_W-1:0] pc,
                                                 input logic [BANK_W-1:0] k);
    return pc + (PC_W'(k) << BYTE_OFFSET);
  endfunction

  function automatic logic [BANK_W-1:0] addr_bank(input logic [PC_W-1:0] a);
    return BANK_W'((a >> BYTE_OFFSET) & PC_W'(FETCH_WIDTH - 1));
  endfunction

  function automatic logic [SETS_LOG-1:0] addr_set(input logic [PC_W-1:0] a);
    return SETS_LOG'(a >> (BYTE_OFFSET + FW_LOG));
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [PC_W-1:0] a);
    return TAG_W'(a >> (BYTE_OFFSET + FW_LOG + SETS_LOG));
  endfunction

endpackage

// File: rtl/btb_bank.sv
// One BTB bank: WAYS-way set-associative storage with round-robin victim pointers,
// one combinational read port, one write port and a whole-set clear port.
module btb_bank
  import btb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SETS_LOG-1:0]    rd_set,
  input  logic [TAG_W-1:0]       rd_tag,
  output logic                   rd_hit,
  output logic [PC_W-1:0]        rd_target,
  output logic [BRANCH_TYPE-1:0] rd_ctype,
  input  logic                   wr_en,
  input  logic [SETS_LOG-1:0]    wr_set,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic [PC_W-1:0]        wr_target,
  input  logic [BRANCH_TYPE-1:0] wr_ctype,
  input  logic                   clr_en,
  input  logic [SETS_LOG-1:0]    clr_set
);

  entry_t             mem [SETS][WAYS];
  logic [WAY_LOG-1:0] ptr [SETS];

  logic               wr_hit, wr_free, wr_bump;
  logic [WAY_LOG-1:0] hit_way, free_way, wr_way;

  // Lowest matching way wins should a multi-hit ever occur.
  always_comb begin
    rd_hit    = 1'b0;
    rd_target = '0;
    rd_ctype  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!rd_hit && mem[rd_set][w].valid && (mem[rd_set][w].tag == rd_tag)) begin
        rd_hit    = 1'b1;
        rd_target = mem[rd_set][w].target;
        rd_ctype  = mem[rd_set][w].ctype;
      end
    end
  end

  always_comb begin
    wr_hit   = 1'b0;
    wr_free  = 1'b0;
    hit_way  = '0;
    free_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!wr_hit && mem[wr_set][w].valid && (mem[wr_set][w].tag == wr_tag)) begin
        wr_hit  = 1'b1;
        hit_way = WAY_LOG'(w);
      end
      if (!wr_free && !mem[wr_set][w].valid) begin
        wr_free  = 1'b1;
        free_way = WAY_LOG'(w);
      end
    end
    wr_bump = !wr_hit && !wr_free;
    if (wr_hit)       wr_way = hit_way;
    else if (wr_free) wr_way = free_way;
    else              wr_way = ptr[wr_set];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        ptr[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) mem[s][w].valid <= 1'b0;
      end
    end else if (clr_en) begin
      ptr[clr_set] <= '0;
      for (int unsigned w = 0; w < WAYS; w++) mem[clr_set][w].valid <= 1'b0;
    end else if (wr_en) begin
      mem[wr_set][wr_way] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, ctype: wr_ctype};
      if (wr_bump) ptr[wr_set] <= (ptr[wr_set] == WAY_LOG'(WAYS - 1)) ? '0 : ptr[wr_set] + 1'b1;
    end
  end

endmodule

// File: rtl/btb_assoc_banked.sv
// Banked set-associative fetch BTB: lane-to-bank rotation, registered lookup stage
// with stall hold and lane masking, and a set-by-set flush sequencer.
module btb_assoc_banked
  import btb_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic [PC_W-1:0]                     pc_i,
  input  logic                                lookupEn_i,
  input  logic                                stall_i,
  input  logic [FETCH_WIDTH-1:0]              laneEnable_i,
  input  logic                                updateEn_i,
  input  logic [PC_W-1:0]                     updatePC_i,
  input  logic [PC_W-1:0]                     updateTarget_i,
  input  logic [BRANCH_TYPE-1:0]              updateType_i,
  input  logic                                flush_i,
  output logic [FETCH_WIDTH-1:0]              hit_o,
  output logic [FETCH_WIDTH*PC_W-1:0]         target_o,
  output logic [FETCH_WIDTH*BRANCH_TYPE-1:0]  ctrlType_o,
  output logic                                flushBusy_o
);

  flush_state_e        state_q, state_d;
  logic [SETS_LOG-1:0] cnt_q, cnt_d;
  logic                clearing;
  logic [BANK_W-1:0]   base_bank, wr_bank, src_bank;

  logic                   bank_hit    [FETCH_WIDTH];
  logic [PC_W-1:0]        bank_target [FETCH_WIDTH];
  logic [BRANCH_TYPE-1:0] bank_ctype  [FETCH_WIDTH];

  logic [FETCH_WIDTH-1:0]             hit_d, hit_q;
  logic [FETCH_WIDTH*PC_W-1:0]        target_d, target_q;
  logic [FETCH_WIDTH*BRANCH_TYPE-1:0] ctype_d, ctype_q;

  assign clearing  = (state_q == CLEAR);
  assign base_bank = addr_bank(pc_i);
  assign wr_bank   = addr_bank(updatePC_i);

  // Bank j serves the lane whose address lands in it: lane = (j - base_bank) mod FETCH_WIDTH.
  for (genvar j = 0; j < FETCH_WIDTH; j++) begin : g_bank
    logic [BANK_W-1:0] lane;
    logic [PC_W-1:0]   rd_addr;
    assign lane    = BANK_W'(j) - base_bank;
    assign rd_addr = lane_addr(pc_i, lane);

    btb_bank u_bank (
      .clk       (clk),
      .reset     (reset),
      .rd_set    (addr_set(rd_addr)),
      .rd_tag    (addr_tag(rd_addr)),
      .rd_hit    (bank_hit[j]),
      .rd_target (bank_target[j]),
      .rd_ctype  (bank_ctype[j]),
      .wr_en     (updateEn_i && !clearing && (wr_bank == BANK_W'(j))),
      .wr_set    (addr_set(updatePC_i)),
      .wr_tag    (addr_tag(updatePC_i)),
      .wr_target (updateTarget_i),
      .wr_ctype  (updateType_i),
      .clr_en    (clearing),
      .clr_set   (cnt_q)
    );
  end

  always_comb begin
    hit_d    = '0;
    target_d = '0;
    ctype_d  = '0;
    src_bank = '0;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      src_bank = BANK_W'(k) + base_bank;
      if (lookupEn_i && laneEnable_i[k] && !clearing && bank_hit[src_bank]) begin
        hit_d[k]                             = 1'b1;
        target_d[k*PC_W +: PC_W]             = bank_target[src_bank];
        ctype_d[k*BRANCH_TYPE +: BRANCH_TYPE] = bank_ctype[src_bank];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_q    <= '0;
      target_q <= '0;
      ctype_q  <= '0;
    end else if (!stall_i) begin
      hit_q    <= hit_d;
      target_q <= target_d;
      ctype_q  <= ctype_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (flush_i)                               cnt_d   = '0;
        else if (cnt_q == SETS_LOG'(SETS - 1))     state_d = IDLE;
        else                                       cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hit_o       = hit_q;
  assign target_o    = target_q;
  assign ctrlType_o  = ctype_q;
  assign flushBusy_o = clearing;

endmodule

// File: tb/tb_btb_assoc_banked.sv
// Bench for btb_assoc_banked: directed scenarios plus randomized traffic checked against
// an address-level reference model of the banked set-associative BTB.
module tb_btb_assoc_banked;

  localparam int NB = 4;
  localparam int NS = 128;
  localparam int NW = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  pc_i = '0;
  logic         lookupEn_i = 1'b0;
  logic         stall_i = 1'b0;
  logic [3:0]   laneEnable_i = '0;
  logic         updateEn_i = 1'b0;
  logic [31:0]  updatePC_i = '0;
  logic [31:0]  updateTarget_i = '0;
  logic [1:0]   updateType_i = '0;
  logic         flush_i = 1'b0;
  logic [3:0]   hit_o;
  logic [127:0] target_o;
  logic [7:0]   ctrlType_o;
  logic         flushBusy_o;

  always #5 clk = ~clk;

  btb_assoc_banked dut (
    .clk            (clk),
    .reset          (reset),
    .pc_i           (pc_i),
    .lookupEn_i     (lookupEn_i),
    .stall_i        (stall_i),
    .laneEnable_i   (laneEnable_i),
    .updateEn_i     (updateEn_i),
    .updatePC_i     (updatePC_i),
    .updateTarget_i (updateTarget_i),
    .updateType_i   (updateType_i),
    .flush_i        (flush_i),
    .hit_o          (hit_o),
    .target_o       (target_o),
    .ctrlType_o     (ctrlType_o),
    .flushBusy_o    (flushBusy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: entries addressed as [bank][set][way] from plain address arithmetic.
  bit          m_valid [NB][NS][NW];
  int unsigned m_tag   [NB][NS][NW];
  logic [31:0] m_tgt   [NB][NS][NW];
  logic [1:0]  m_typ   [NB][NS][NW];
  int          m_ptr   [NB][NS];
  int          flush_left = 0;

  logic [3:0]   exp_hit = '0;
  logic [127:0] exp_tgt = '0;
  logic [7:0]   exp_typ = '0;
  logic         exp_busy = 1'b0;

  task automatic model_clear();
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++) begin
        m_ptr[b][s] = 0;
        for (int w = 0; w < NW; w++) m_valid[b][s][w] = 1'b0;
      end
  endtask

  task automatic model_find(input logic [31:0] a, output int b, output int s,
                            output bit found, output int way);
    b = int'((a >> 3) % NB);
    s = int'((a >> 5) % NS);
    found = 1'b0;
    way = 0;
    for (int w = NW - 1; w >= 0; w--)
      if (m_valid[b][s][w] && m_tag[b][s][w] == (a >> 12)) begin
        found = 1'b1;
        way = w;
      end
  endtask

  task automatic model_update(input logic [31:0] a, input logic [31:0] t, input logic [1:0] ty);
    int b, s, w;
    bit f;
    model_find(a, b, s, f, w);
    if (!f) begin
      w = -1;
      for (int i = NW - 1; i >= 0; i--) if (!m_valid[b][s][i]) w = i;
      if (w < 0) begin
        w = m_ptr[b][s];
        m_ptr[b][s] = (m_ptr[b][s] + 1) % NW;
      end
    end
    m_valid[b][s][w] = 1'b1;
    m_tag[b][s][w]   = a >> 12;
    m_tgt[b][s][w]   = t;
    m_typ[b][s][w]   = ty;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] a;
    int b, s, w;
    bit f;
    if (!reset) begin
      model_clear();
      exp_hit = '0; exp_tgt = '0; exp_typ = '0;
      flush_left = 0; exp_busy = 1'b0;
      return;
    end
    if (!stall_i) begin
      exp_hit = '0; exp_tgt = '0; exp_typ = '0;
      for (int k = 0; k < NB; k++) begin
        a = pc_i + 32'(k * 8);
        model_find(a, b, s, f, w);
        if (lookupEn_i && laneEnable_i[k] && f && flush_left == 0) begin
          exp_hit[k] = 1'b1;
          exp_tgt[k*32 +: 32] = m_tgt[b][s][w];
          exp_typ[k*2 +: 2] = m_typ[b][s][w];
        end
      end
    end
    if (updateEn_i && flush_left == 0) model_update(updatePC_i, updateTarget_i, updateType_i);
    if (flush_i) begin
      model_clear();
      flush_left = NS;
    end else if (flush_left > 0) flush_left--;
    exp_busy = (flush_left > 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_update(input logic [31:0] a, input logic [31:0] t, input logic [1:0] ty);
    updateEn_i = 1'b1; updatePC_i = a; updateTarget_i = t; updateType_i = ty;
    tick();
    updateEn_i = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] a, input logic [3:0] en);
    lookupEn_i = 1'b1; pc_i = a; laneEnable_i = en;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (hit_o !== 4'b0) begin n_bad++; $display("FAIL reset_hit: got %b want 0000", hit_o); end
    n_cmp++; if (target_o !== 128'b0) begin n_bad++; $display("FAIL reset_target: got %h want 0", target_o); end
    n_cmp++; if (ctrlType_o !== 8'b0) begin n_bad++; $display("FAIL reset_type: got %h want 0", ctrlType_o); end
    n_cmp++; if (flushBusy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", flushBusy_o); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_rotation();
    do_update(32'h1000, 32'h2000, 2'd1);
    do_lookup(32'h1000, 4'hF);
    n_cmp++; if (hit_o !== 4'b0001) begin n_bad++; $display("FAIL basic_hit: got %b want 0001", hit_o); end
    n_cmp++; if (target_o[31:0] !== 32'h2000) begin n_bad++; $display("FAIL basic_target: got %h want 2000", target_o[31:0]); end
    n_cmp++; if (ctrlType_o[1:0] !== 2'd1) begin n_bad++; $display("FAIL basic_type: got %0d want 1", ctrlType_o[1:0]); end
    n_cmp++; if (target_o !== exp_tgt) begin n_bad++; $display("FAIL basic_all_targets: got %h want %h", target_o, exp_tgt); end
    do_lookup(32'h0FF8, 4'hF);
    n_cmp++; if (hit_o !== 4'b0010) begin n_bad++; $display("FAIL rot_hit: got %b want 0010", hit_o); end
    n_cmp++; if (target_o[63:32] !== 32'h2000) begin n_bad++; $display("FAIL rot_target: got %h want 2000", target_o[63:32]); end
    do_lookup(32'h0FF8, 4'b1101);
    n_cmp++; if (hit_o !== 4'b0000) begin n_bad++; $display("FAIL lane_mask_hit: got %b want 0000", hit_o); end
    n_cmp++; if (target_o !== 128'b0) begin n_bad++; $display("FAIL lane_mask_target: got %h want 0", target_o); end
  endtask

  task automatic test_replacement();
    do_update(32'h11040, 32'hA0, 2'd0);
    do_update(32'h22040, 32'hB0, 2'd1);
    do_update(32'h33040, 32'hC0, 2'd2);
    do_lookup(32'h11040, 4'hF);
    n_cmp++; if (hit_o[0] !== 1'b0) begin n_bad++; $display("FAIL evict_a: got %b want 0", hit_o[0]); end
    do_lookup(32'h22040, 4'hF);
    n_cmp++; if (target_o[31:0] !== 32'hB0 || hit_o[0] !== 1'b1) begin n_bad++; $display("FAIL keep_b: got hit %b tgt %h want 1 b0", hit_o[0], target_o[31:0]); end
    do_lookup(32'h33040, 4'hF);
    n_cmp++; if (target_o[31:0] !== 32'hC0 || hit_o[0] !== 1'b1) begin n_bad++; $display("FAIL alloc_c: got hit %b tgt %h want 1 c0", hit_o[0], target_o[31:0]); end
    // Pointer should now be 1, so D evicts B and keeps C.
    do_update(32'h44040, 32'hD0, 2'd3);
    do_lookup(32'h22040, 4'hF);
    n_cmp++; if (hit_o[0] !== 1'b0) begin n_bad++; $display("FAIL ptr_evict_b: got %b want 0", hit_o[0]); end
    do_lookup(32'h33040, 4'hF);
    n_cmp++; if (hit_o[0] !== 1'b1) begin n_bad++; $display("FAIL ptr_keep_c: got %b want 1", hit_o[0]); end
    do_update(32'h33040, 32'hC1, 2'd1);
    do_lookup(32'h33040, 4'hF);
    n_cmp++; if (target_o[31:0] !== 32'hC1 || ctrlType_o[1:0] !== 2'd1) begin n_bad++; $display("FAIL overwrite_c: got %h/%0d want c1/1", target_o[31:0], ctrlType_o[1:0]); end
    do_lookup(32'h44040, 4'hF);
    n_cmp++; if (target_o[31:0] !== 32'hD0 || hit_o[0] !== 1'b1) begin n_bad++; $display("FAIL overwrite_no_evict: got hit %b tgt %h want 1 d0", hit_o[0], target_o[31:0]); end
  endtask

  task automatic test_flush();
    int busy_cycles = 0;
    int guard = 0;
    int hit_errs = 0;
    lookupEn_i = 1'b1; pc_i = 32'h1000; laneEnable_i = 4'hF;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    if (flushBusy_o === 1'b1) busy_cycles = 1;
    while (flushBusy_o === 1'b1 && guard < 300) begin
      updateEn_i = (guard == 5);
      updatePC_i = 32'h5000; updateTarget_i = 32'h5500; updateType_i = 2'd2;
      tick();
      guard++;
      if (flushBusy_o === 1'b1) busy_cycles++;
      if (hit_o !== 4'b0) hit_errs++;
    end
    updateEn_i = 1'b0;
    n_cmp++; if (busy_cycles != NS) begin n_bad++; $display("FAIL flush_busy_len: got %0d want %0d", busy_cycles, NS); end
    n_cmp++; if (hit_errs != 0) begin n_bad++; $display("FAIL flush_hits_during: got %0d nonzero want 0", hit_errs); end
    do_lookup(32'h1000, 4'hF);
    n_cmp++; if (hit_o !== 4'b0) begin n_bad++; $display("FAIL flush_old_entry: got %b want 0000", hit_o); end
    do_lookup(32'h5000, 4'hF);
    n_cmp++; if (hit_o !== 4'b0) begin n_bad++; $display("FAIL flush_dropped_update: got %b want 0000", hit_o); end
  endtask

  task automatic test_stall();
    do_update(32'h3000, 32'h3300, 2'd2);
    do_lookup(32'h3000, 4'hF);
    n_cmp++; if (hit_o !== 4'b0001) begin n_bad++; $display("FAIL stall_pre_hit: got %b want 0001", hit_o); end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_i = $urandom & 32'hFFFF_FFF8;
      updateEn_i = (i == 1);
      updatePC_i = 32'h7000; updateTarget_i = 32'h7700; updateType_i = 2'd3;
      tick();
      n_cmp++;
      if (hit_o !== 4'b0001 || target_o[31:0] !== 32'h3300 || ctrlType_o[1:0] !== 2'd2) begin
        n_bad++; $display("FAIL stall_hold: got %b %h %0d want 0001 3300 2", hit_o, target_o[31:0], ctrlType_o[1:0]);
      end
    end
    stall_i = 1'b0; updateEn_i = 1'b0;
    do_lookup(32'h7000, 4'hF);
    n_cmp++; if (hit_o !== 4'b0001 || target_o[31:0] !== 32'h7700) begin n_bad++; $display("FAIL stall_update: got %b %h want 0001 7700", hit_o, target_o[31:0]); end
  endtask

  task automatic test_reset_midflush();
    do_update(32'h5C80, 32'h5C00, 2'd1);
    do_lookup(32'h5C80, 4'hF);
    n_cmp++; if (hit_o !== 4'b0001) begin n_bad++; $display("FAIL midflush_pre: got %b want 0001", hit_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (flushBusy_o !== 1'b1) begin n_bad++; $display("FAIL midflush_busy: got %b want 1", flushBusy_o); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++; if (flushBusy_o !== 1'b0) begin n_bad++; $display("FAIL midflush_reset_busy: got %b want 0", flushBusy_o); end
    n_cmp++; if (hit_o !== 4'b0 || target_o !== 128'b0 || ctrlType_o !== 8'b0) begin n_bad++; $display("FAIL midflush_reset_out: got %b %h %h want 0", hit_o, target_o, ctrlType_o); end
    do_lookup(32'h5C80, 4'hF);
    n_cmp++; if (hit_o !== 4'b0) begin n_bad++; $display("FAIL midflush_entry_gone: got %b want 0000", hit_o); end
    do_lookup(32'h7000, 4'hF);
    n_cmp++; if (hit_o !== 4'b0) begin n_bad++; $display("FAIL midflush_entry2_gone: got %b want 0000", hit_o); end
  endtask

  function automatic logic [31:0] pool_pc();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 8);
    return (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 3)) << 3);
  endfunction

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset        = ($urandom_range(0, 299) != 0);
      pc_i         = pool_pc();
      lookupEn_i   = ($urandom_range(0, 7) != 0);
      laneEnable_i = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
      stall_i      = ($urandom_range(0, 9) == 0);
      updateEn_i   = $urandom_range(0, 1);
      updatePC_i   = pool_pc();
      updateTarget_i = $urandom;
      updateType_i = 2'($urandom_range(0, 3));
      flush_i      = ($urandom_range(0, 249) == 0);
      tick();
      n_cmp++; if (hit_o !== exp_hit) begin n_bad++; $display("FAIL rand_hit @%0d: got %b want %b", i, hit_o, exp_hit); end
      n_cmp++; if (target_o !== exp_tgt) begin n_bad++; $display("FAIL rand_target @%0d: got %h want %h", i, target_o, exp_tgt); end
      n_cmp++; if (ctrlType_o !== exp_typ) begin n_bad++; $display("FAIL rand_type @%0d: got %h want %h", i, ctrlType_o, exp_typ); end
      n_cmp++; if (flushBusy_o !== exp_busy) begin n_bad++; $display("FAIL rand_busy @%0d: got %b want %b", i, flushBusy_o, exp_busy); end
    end
    reset = 1'b1; updateEn_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_rotation();
    test_replacement();
    test_flush();
    test_stall();
    test_reset_midflush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
